// File: rtl/fp_result_stage.sv
// fp_result_stage
//   Registered output stage behind the combinational fp_add / fp_sub datapath.
//   Each accepted result word is stored with a 3-bit encoded class in a
//   2-entry skid buffer (main + skid register), so the stage takes one result
//   per clock while cutting every combinational path to the consumer.
//   Also keeps sticky exception flags and a count of accepted results.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high (accept = in_valid & in_ready, deliver = out_valid & out_ready).
//   in_ready and out_valid are registers that depend on buffer state only.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_result             result word from fp_add / fp_sub
//   in_snan..in_normal    one-hot classification flags of in_result
//   out_valid/out_ready   downstream handshake
//   out_result/out_class  registered word and class (0 zero, 1 subnormal,
//                         2 normal, 3 inf, 4 qNaN, 5 sNaN, 7 malformed)
//   sticky_clr            synchronous clear of sticky_flags
//   sticky_flags          {malformed, subnormal, inf, qNaN, sNaN}
//   result_count          accepted-result counter, wraps
//   dbg_state             buffer state (0 EMPTY, 1 ONE, 2 TWO)
module fp_result_stage #(
  parameter int PRECISION = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRECISION-1:0] in_result,
  input  logic                 in_snan,
  input  logic                 in_qnan,
  input  logic                 in_inf,
  input  logic                 in_zero,
  input  logic                 in_subnormal,
  input  logic                 in_normal,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRECISION-1:0] out_result,
  output logic [2:0]           out_class,
  input  logic                 sticky_clr,
  output logic [4:0]           sticky_flags,
  output logic [CNT_W-1:0]     result_count,
  output logic [1:0]           dbg_state
);

  localparam int PW = PRECISION + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    main_q;
  logic [PW-1:0]    skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [4:0]       sticky_q;
  logic [CNT_W-1:0] count_q;

  logic [2:0]    in_class;
  logic          malformed;
  logic          accept;
  logic          deliver;
  logic [PW-1:0] payload;
  logic [4:0]    sticky_new;

  // Exactly one flag set selects its code; anything else is malformed.
  always_comb begin
    in_class = 3'd7;
    case ({in_snan, in_qnan, in_inf, in_zero, in_subnormal, in_normal})
      6'b100000: in_class = 3'd5;
      6'b010000: in_class = 3'd4;
      6'b001000: in_class = 3'd3;
      6'b000100: in_class = 3'd0;
      6'b000010: in_class = 3'd1;
      6'b000001: in_class = 3'd2;
      default:   in_class = 3'd7;
    endcase
  end

  assign malformed  = (in_class == 3'd7);
  assign accept     = in_valid & in_ready_q;
  assign deliver    = out_valid_q & out_ready;
  assign payload    = {in_result, in_class};
  assign sticky_new = {malformed, in_subnormal, in_inf, in_qnan, in_snan};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sticky_q    <= '0;
      count_q     <= '0;
    end else begin
      if (accept) count_q <= count_q + 1'b1;

      // New flags win over a simultaneous clear.
      if (accept)          sticky_q <= (sticky_clr ? 5'd0 : sticky_q) | sticky_new;
      else if (sticky_clr) sticky_q <= 5'd0;

      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q      <= payload;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_q <= payload;
          end else if (accept) begin
            skid_q     <= payload;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (deliver) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so no accept can collide with the move.
          if (deliver) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = main_q[PW-1:3];
  assign out_class    = main_q[2:0];
  assign sticky_flags = sticky_q;
  assign result_count = count_q;
  assign dbg_state    = state_q;

endmodule
